// File: rtl/rtc_time_set_ctrl.sv
// Manual time-set sequencer for the HH:MM:SS counter: syncs switch/buttons,
// debounces with auto-repeat, edits a shadow time and commits it with a load.
// Ports: clock50MHz, resetn (async low), man_switch, push_button[2:0] (low),
//   cur_hh/mm/ss in; count_hold, set_load, set_hh/mm/ss, set_state out.
module rtc_time_set_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int DB_SAMPLES   = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 200
) (
  input  logic       clock50MHz,
  input  logic       resetn,
  input  logic       man_switch,
  input  logic [2:0] push_button,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [5:0] cur_ss,
  output logic       count_hold,
  output logic       set_load,
  output logic [4:0] set_hh,
  output logic [5:0] set_mm,
  output logic [5:0] set_ss,
  output logic [1:0] set_state
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int DB = DB_SAMPLES;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    CAPTURE = 2'b01,
    SET     = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  logic [1:0] sw_sync;
  logic [2:0] pb_s1;
  logic [2:0] pb_s2;
  logic       sw;
  logic [2:0] lvl;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  logic [2:0][DB-1:0] sh, sh_n;
  logic [2:0][RW-1:0] rpt, rpt_n;
  logic [2:0]         db, db_n;
  logic [2:0]         evt, evt_n;

  state_t     state, state_n;
  logic [4:0] hh_n;
  logic [5:0] mm_n;
  logic [5:0] ss_n;

  assign sw  = sw_sync[1];
  assign lvl = ~pb_s2;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      sw_sync <= '0;
      pb_s1   <= '1;
      pb_s2   <= '1;
    end else begin
      sw_sync <= {sw_sync[0], man_switch};
      pb_s1   <= push_button;
      pb_s2   <= pb_s1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Repeat counter runs while the debounced level is held; reaching
  // the delay re-arms it so later repeats come every REPEAT_RATE ticks.
  always_comb begin
    sh_n  = sh;
    db_n  = db;
    rpt_n = rpt;
    evt_n = '0;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        sh_n[i] = {sh[i][DB-2:0], lvl[i]};
        if (&sh_n[i]) db_n[i] = 1'b1;
        else if (~|sh_n[i]) db_n[i] = 1'b0;
        if (db_n[i] && !db[i]) begin
          evt_n[i] = 1'b1;
          rpt_n[i] = '0;
        end else if (db_n[i]) begin
          if (rpt[i] == RW'(REPEAT_DELAY - 1)) begin
            evt_n[i] = 1'b1;
            rpt_n[i] = RW'(REPEAT_DELAY - REPEAT_RATE);
          end else begin
            rpt_n[i] = rpt[i] + 1'b1;
          end
        end else begin
          rpt_n[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      sh  <= '0;
      db  <= '0;
      rpt <= '0;
      evt <= '0;
    end else begin
      sh  <= sh_n;
      db  <= db_n;
      rpt <= rpt_n;
      evt <= evt_n;
    end
  end

  always_comb begin
    state_n = state;
    hh_n    = set_hh;
    mm_n    = set_mm;
    ss_n    = set_ss;
    unique case (state)
      RUN: begin
        if (sw) state_n = CAPTURE;
      end
      CAPTURE: begin
        hh_n    = cur_hh;
        mm_n    = cur_mm;
        ss_n    = cur_ss;
        state_n = SET;
      end
      SET: begin
        if (evt[2]) hh_n = (set_hh == 5'd23) ? 5'd0 : set_hh + 5'd1;
        if (evt[1]) mm_n = (set_mm == 6'd59) ? 6'd0 : set_mm + 6'd1;
        if (evt[0]) ss_n = (set_ss == 6'd59) ? 6'd0 : set_ss + 6'd1;
        if (!sw) state_n = COMMIT;
      end
      COMMIT: begin
        state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      state      <= RUN;
      count_hold <= 1'b0;
      set_load   <= 1'b0;
      set_hh     <= '0;
      set_mm     <= '0;
      set_ss     <= '0;
    end else begin
      state      <= state_n;
      count_hold <= (state_n != RUN);
      set_load   <= (state_n == COMMIT);
      set_hh     <= hh_n;
      set_mm     <= mm_n;
      set_ss     <= ss_n;
    end
  end

  assign set_state = state;

endmodule
